pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Central hazard/sequencing controller for the 5-stage RV32 pipeline (F/D/E/M/W).
//  Generates operand forwarding selects for E, load-use stall, branch/jump flush
//  and a data-memory wait stall driven by a req/ready handshake.
//  Contains a 3-state FSM with a timeout counter; outputs feed the stage registers
//  (StallF/StallD/FlushD/FlushE/StallE/StallM/FlushW) and the E-stage forwarding muxes.
// PARAMETERS
//  MEM_TIMEOUT  16  max consecutive MEM_WAIT cycles before ERROR (>=2)
//  CNT_W        32  width of perf counters (only with PERF_CNT_EN)
// PORTS
//  clk          in   1   clock
//  rst          in   1   reset, asynchronous, active-high
//  Rs1D,Rs2D    in   5   source regs of instr in D
//  Rs1E,Rs2E    in   5   source regs of instr in E
//  RdE,RdM,RdW  in   5   dest regs in E/M/W
//  ResultSrcE   in   2   2'b01 = load in E
//  RegWriteM    in   1   M instr writes RF
//  RegWriteW    in   1   W instr writes RF
//  PCSrcE       in   1   taken branch/jump resolved in E
//  MemReqM      in   1   M instr accesses data memory
//  MemReadyM    in   1   data memory completes access this cycle
//  ForwardAE    out  2   operand A select: 00 RF, 01 ResultW, 10 ALUResultM
//  ForwardBE    out  2   operand B select, same encoding
//  StallF,StallD out 1   hold PC / IF-ID register
//  StallE,StallM out 1   hold ID-EX / EX-MEM register
//  FlushD,FlushE out 1   bubble into IF-ID / ID-EX register
//  FlushW       out  1   bubble into MEM-WB register
//  MemErr       out  1   sticky: memory timeout occurred
//  StallCnt,FlushCnt out CNT_W  perf counters (PERF_CNT_EN only)
// BEHAVIOUR
//  - State: RUN, MEM_WAIT, ERROR; reset -> RUN, wait counter 0, MemErr 0, perf counters 0.
//  - Outputs combinational from inputs + state; with rst high and all inputs 0 every output is 0.
//  - Forwarding (per operand, RsXE): RsXE!=0 & RegWriteM & RdM==RsXE -> 10; else
//    RsXE!=0 & RegWriteW & RdW==RsXE -> 01; else 00. M wins over W. x0 never forwarded.
//  - lwStall = ResultSrcE==01 & RdE!=0 & (Rs1D==RdE | Rs2D==RdE).
//  - memStall = (RUN & MemReqM & ~MemReadyM) | (MEM_WAIT & ~MemReadyM) | ERROR.
//  - memStall=1: StallF=StallD=StallE=StallM=1, FlushW=1, FlushD=FlushE=0 (branch/load-use
//    deferred; E is frozen so PCSrcE/lwStall re-evaluate on release).
//  - memStall=0: StallF=StallD=lwStall; FlushD=PCSrcE; FlushE=lwStall|PCSrcE;
//    StallE=StallM=FlushW=0. lwStall & PCSrcE together: both apply (flush wins in D).
//  - Transitions: RUN->MEM_WAIT when MemReqM & ~MemReadyM (cnt<=1).
//    MEM_WAIT: MemReadyM -> RUN (cnt<=0); else cnt==MEM_TIMEOUT-1 -> ERROR, MemErr<=1; else cnt++.
//    ERROR: absorbing until rst. Ready in the same cycle as req: no stall, stay RUN.
//  - Latency: memory access with ready after k cycles stalls exactly k cycles.
//  - Reset mid-MEM_WAIT: immediate return to RUN, all stalls drop asynchronously.
// CONFIGURATION
//  PERF_CNT_EN defined: StallCnt increments every cycle memStall|lwStall=1; FlushCnt
//   increments every cycle FlushE=1 due to PCSrcE; both saturate at all-ones; ports exist.
//  PERF_CNT_EN undefined: counters and StallCnt/FlushCnt ports absent; rest identical.
// STRUCTURE
//  Shared package/constants file: FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10,
//   RESULT_SRC_LOAD=2'b01, FSM state encoding (RUN=0, MEM_WAIT=1, ERROR=2).
//  One sub-module: forward_sel (RsE,RdM,RdW,RegWriteM,RegWriteW -> 2-bit sel), instanced for A and B.
// TESTING
//  1 RdM=5,RegWriteM=1,RdW=5,RegWriteW=1,Rs1E=5 -> ForwardAE=10; RdM=0 variant -> 01.
//  2 Rs2E=0,RdM=0,RegWriteM=1 -> ForwardBE=00 (x0 never forwarded).
//  3 ResultSrcE=01,RdE=7,Rs2D=7 -> StallF=StallD=FlushE=1, FlushD=0 for one cycle.
//  4 PCSrcE=1 -> FlushD=FlushE=1, no stalls; with PERF_CNT_EN FlushCnt +1.
//  5 MemReqM=1, MemReadyM low 3 cycles then high -> StallF/D/E/M,FlushW high exactly 3 cycles, state RUN after.
//  6 MemReadyM held 0 for MEM_TIMEOUT=16 cycles -> ERROR, MemErr=1, stalls stick; rst pulse -> all 0, RUN.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl_pkg
//   Constants and types for the RV32 5-stage pipeline hazard controller:
//   - forwarding-mux select encodings used by the E-stage operand muxes
//   - the ResultSrc encoding that marks a load instruction
//   - the memory-handshake FSM state type
//   - a helper that evaluates the load-use hazard condition
// ---------------------------------------------------------------------------
package pipeline_hazard_ctrl_pkg;

  // E-stage operand select encodings
  localparam logic [1:0] FWD_RF  = 2'b00;  // value read from the register file
  localparam logic [1:0] FWD_WB  = 2'b01;  // ResultW from the W stage
  localparam logic [1:0] FWD_MEM = 2'b10;  // ALUResultM from the M stage

  // ResultSrc value identifying a load instruction
  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

  // Data-memory handshake FSM
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } hazState_t;

  // A load in E whose destination is read by the instruction in D cannot be
  // forwarded in time, so D must wait one cycle. x0 is never a hazard.
  function automatic logic isLoadUse(
    input logic [1:0] resultSrcE,
    input logic [4:0] rdE,
    input logic [4:0] rs1D,
    input logic [4:0] rs2D
  );
    return (resultSrcE == RESULT_SRC_LOAD) && (rdE != 5'd0) &&
           ((rs1D == rdE) || (rs2D == rdE));
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_forward_sel.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl_forward_sel
//   Forwarding select for one E-stage source operand.
//   Ports:
//     RsE        in  5  source register of the instruction in E
//     RdM, RdW   in  5  destination registers of the instructions in M / W
//     RegWriteM  in  1  instruction in M writes the register file
//     RegWriteW  in  1  instruction in W writes the register file
//     Sel        out 2  FWD_RF / FWD_WB / FWD_MEM
//   The younger producer (M) takes priority over the older one (W); x0 is
//   hard-wired to zero and is therefore never forwarded.
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl_forward_sel
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic [4:0] RsE,
  input  logic [4:0] RdM,
  input  logic [4:0] RdW,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  output logic [1:0] Sel
);

  always_comb begin
    Sel = FWD_RF;
    if (RsE != 5'd0) begin
      if (RegWriteM && (RdM == RsE)) begin
        Sel = FWD_MEM;
      end else if (RegWriteW && (RdW == RsE)) begin
        Sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
//   Central hazard / sequencing controller for the 5-stage RV32 pipeline.
//   Produces E-stage forwarding selects, load-use stall, branch/jump flush and
//   a data-memory wait stall driven by a MemReqM / MemReadyM handshake.
//
//   Parameters:
//     MEM_TIMEOUT  max consecutive not-ready cycles of one access (>= 2)
//     CNT_W        perf counter width (only when PERF_CNT_EN is defined)
//
//   Ports:
//     clk, rst                 clock; asynchronous active-high reset
//     Rs1D, Rs2D         in 5  sources of the instruction in D
//     Rs1E, Rs2E         in 5  sources of the instruction in E
//     RdE, RdM, RdW      in 5  destinations in E / M / W
//     ResultSrcE         in 2  RESULT_SRC_LOAD marks a load in E
//     RegWriteM/W        in 1  M / W instruction writes the register file
//     PCSrcE             in 1  taken branch/jump resolved in E
//     MemReqM            in 1  M instruction accesses data memory
//     MemReadyM          in 1  data memory completes the access this cycle
//     ForwardAE/BE       out 2 operand A / B select
//     StallF, StallD     out 1 hold PC / IF-ID
//     StallE, StallM     out 1 hold ID-EX / EX-MEM
//     FlushD, FlushE     out 1 bubble into IF-ID / ID-EX
//     FlushW             out 1 bubble into MEM-WB
//     MemErr             out 1 sticky memory-timeout flag
//     StallCnt, FlushCnt out CNT_W  saturating perf counters (PERF_CNT_EN)
//
//   Build option: define PERF_CNT_EN to add the StallCnt / FlushCnt counters
//   and their ports; without it the controller is otherwise identical.
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
`ifdef PERF_CNT_EN
  ,
  parameter int CNT_W = 32
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] Rs1D,
  input  logic [4:0] Rs2D,
  input  logic [4:0] Rs1E,
  input  logic [4:0] Rs2E,
  input  logic [4:0] RdE,
  input  logic [4:0] RdM,
  input  logic [4:0] RdW,
  input  logic [1:0] ResultSrcE,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       PCSrcE,
  input  logic       MemReqM,
  input  logic       MemReadyM,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       StallM,
  output logic       FlushD,
  output logic       FlushE,
  output logic       FlushW,
  output logic       MemErr
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
`endif
);

  // The wait counter only has to reach MEM_TIMEOUT-1.
  localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  hazState_t         state;
  logic [WAIT_W-1:0] waitCnt;

  logic lwStall;
  logic memStall;
  logic branchFlush;

  // ---------------------------------------------------------------------
  // Operand forwarding: one selector per E-stage source operand.
  // ---------------------------------------------------------------------
  logic [4:0] rsE [2];
  logic [1:0] fwdSel [2];

  assign rsE[0] = Rs1E;
  assign rsE[1] = Rs2E;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : gFwd
      pipeline_hazard_ctrl_forward_sel uFwdSel (
        .RsE       (rsE[gi]),
        .RdM       (RdM),
        .RdW       (RdW),
        .RegWriteM (RegWriteM),
        .RegWriteW (RegWriteW),
        .Sel       (fwdSel[gi])
      );
    end
  endgenerate

  assign ForwardAE = fwdSel[0];
  assign ForwardBE = fwdSel[1];

  // ---------------------------------------------------------------------
  // Hazard detection
  // ---------------------------------------------------------------------
  assign lwStall = isLoadUse(ResultSrcE, RdE, Rs1D, Rs2D);

  // A new access that is not ready stalls in its very first cycle, so an
  // access that becomes ready after k cycles stalls exactly k cycles.
  // ERROR keeps the whole pipeline frozen until reset.
  always_comb begin
    memStall = 1'b0;
    case (state)
      RUN:      memStall = MemReqM && !MemReadyM;
      MEM_WAIT: memStall = !MemReadyM;
      ERROR:    memStall = 1'b1;
      default:  memStall = 1'b0;
    endcase
  end

  // While memory is stalling, E is frozen: a pending branch or load-use
  // hazard in E/D is simply re-evaluated once the stall releases, so no
  // flush may be issued now.
  assign branchFlush = !memStall && PCSrcE;

  assign StallF = memStall || lwStall;
  assign StallD = memStall || lwStall;
  assign StallE = memStall;
  assign StallM = memStall;
  assign FlushW = memStall;
  assign FlushD = branchFlush;
  assign FlushE = !memStall && (lwStall || PCSrcE);

  // ---------------------------------------------------------------------
  // Memory handshake FSM with timeout
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RUN;
      waitCnt <= '0;
      MemErr  <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          // The first not-ready cycle already counts toward the timeout.
          if (MemReqM && !MemReadyM) begin
            state   <= MEM_WAIT;
            waitCnt <= WAIT_W'(1);
          end
        end
        MEM_WAIT: begin
          if (MemReadyM) begin
            state   <= RUN;
            waitCnt <= '0;
          end else if (waitCnt == WAIT_LAST) begin
            state  <= ERROR;
            MemErr <= 1'b1;
          end else begin
            waitCnt <= waitCnt + 1'b1;
          end
        end
        ERROR: begin
          state <= ERROR;
        end
        default: begin
          // Unused encoding: treat as a fault and freeze.
          state  <= ERROR;
          MemErr <= 1'b1;
        end
      endcase
    end
  end

`ifdef PERF_CNT_EN
  // ---------------------------------------------------------------------
  // Saturating performance counters
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      StallCnt <= '0;
      FlushCnt <= '0;
    end else begin
      if ((memStall || lwStall) && (StallCnt != {CNT_W{1'b1}})) begin
        StallCnt <= StallCnt + 1'b1;
      end
      if (branchFlush && (FlushCnt != {CNT_W{1'b1}})) begin
        FlushCnt <= FlushCnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//   Self-checking bench: directed scenarios followed by randomized traffic,
//   compared every cycle with a behavioural model of the hazard rules.
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

  localparam int MEM_TIMEOUT = 16;

  logic       clk;
  logic       rst;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0] ResultSrcE;
  logic       RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
`ifdef PERF_CNT_EN
  logic [31:0] StallCnt, FlushCnt;
`endif

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .Rs1D       (Rs1D),
    .Rs2D       (Rs2D),
    .Rs1E       (Rs1E),
    .Rs2E       (Rs2E),
    .RdE        (RdE),
    .RdM        (RdM),
    .RdW        (RdW),
    .ResultSrcE (ResultSrcE),
    .RegWriteM  (RegWriteM),
    .RegWriteW  (RegWriteW),
    .PCSrcE     (PCSrcE),
    .MemReqM    (MemReqM),
    .MemReadyM  (MemReadyM),
    .ForwardAE  (ForwardAE),
    .ForwardBE  (ForwardBE),
    .StallF     (StallF),
    .StallD     (StallD),
    .StallE     (StallE),
    .StallM     (StallM),
    .FlushD     (FlushD),
    .FlushE     (FlushE),
    .FlushW     (FlushW),
    .MemErr     (MemErr)
`ifdef PERF_CNT_EN
    ,
    .StallCnt   (StallCnt),
    .FlushCnt   (FlushCnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: an access is "outstanding" once it has stalled at
  // least once; lowCycles counts its not-ready cycles; err is sticky.
  bit      mErr;
  bit      mOutstanding;
  int      mLowCycles;
  longint  mStallCnt;
  longint  mFlushCnt;

  int checkCnt;
  int errCnt;
  int cycNum;
  logic lastStall;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [1:0] fwdModel(input logic [4:0] rs);
    if (rs == 5'd0) return 2'b00;
    if (RegWriteM && RdM == rs) return 2'b10;
    if (RegWriteW && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic clearIn();
    Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0;
    RdE = '0; RdM = '0; RdW = '0; ResultSrcE = '0;
    RegWriteM = 1'b0; RegWriteW = 1'b0; PCSrcE = 1'b0;
    MemReqM = 1'b0; MemReadyM = 1'b0;
  endtask

  function automatic longint satInc(input longint v);
    return (v >= 64'hFFFF_FFFF) ? v : v + 1;
  endfunction

  // Called at a negedge with inputs already driven; checks, clocks the DUT,
  // advances the model and returns at the next negedge.
  task automatic runCycle(input string name);
    logic expLw, expMs;
    logic [6:0] expCtl, gotCtl;
    #1;
    expLw = (ResultSrcE == 2'b01) && (RdE != 0) && (Rs1D == RdE || Rs2D == RdE);
    expMs = mErr || (!MemReadyM && (mOutstanding || MemReqM));
    expCtl = {expMs | expLw, expMs | expLw, expMs, expMs,
              !expMs & PCSrcE, !expMs & (expLw | PCSrcE), expMs};
    gotCtl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};
    checkVal("ctl", 32'(gotCtl), 32'(expCtl));
    checkVal("fwdA", 32'(ForwardAE), 32'(fwdModel(Rs1E)));
    checkVal("fwdB", 32'(ForwardBE), 32'(fwdModel(Rs2E)));
    checkVal("memErr", 32'(MemErr), 32'(mErr));
`ifdef PERF_CNT_EN
    checkVal("stallCnt", StallCnt, mStallCnt[31:0]);
    checkVal("flushCnt", FlushCnt, mFlushCnt[31:0]);
`endif
    lastStall = StallF;
    $display("cyc %0d %s req=%b rdy=%b pc=%b | sF=%b sD=%b sE=%b sM=%b fD=%b fE=%b fW=%b fa=%b fb=%b err=%b",
             cycNum, name, MemReqM, MemReadyM, PCSrcE, StallF, StallD, StallE, StallM,
             FlushD, FlushE, FlushW, ForwardAE, ForwardBE, MemErr);
    @(posedge clk);
    if (!mErr) begin
      if (expMs) begin
        mOutstanding = 1;
        mLowCycles++;
        if (mLowCycles >= MEM_TIMEOUT) mErr = 1;
      end else begin
        mOutstanding = 0;
        mLowCycles = 0;
      end
    end
    if (expMs || expLw) mStallCnt = satInc(mStallCnt);
    if (!expMs && PCSrcE) mFlushCnt = satInc(mFlushCnt);
    cycNum++;
    @(negedge clk);
  endtask

  // Called at a negedge; asserts reset mid-cycle so the asynchronous drop of
  // every output is observed before any clock edge.
  task automatic doReset();
    clearIn();
    rst = 1'b1;
    #1;
    checkVal("rstOuts", 32'({ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
                             FlushD, FlushE, FlushW, MemErr}), 32'd0);
`ifdef PERF_CNT_EN
    checkVal("rstStallCnt", StallCnt, 32'd0);
    checkVal("rstFlushCnt", FlushCnt, 32'd0);
`endif
    $display("cyc %0d reset", cycNum);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    mErr = 0; mOutstanding = 0; mLowCycles = 0; mStallCnt = 0; mFlushCnt = 0;
  endtask

  initial begin
    int n;
    checkCnt = 0; errCnt = 0; cycNum = 0; lastStall = 1'b0;
    clearIn();
    rst = 1'b1;
    @(negedge clk);
    doReset();

    // 1: M wins over W; with RdM=0 the W copy is used
    clearIn(); Rs1E = 5; RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1;
    runCycle("t1_fwdMem");
    checkVal("t1_fwdA_mem", 32'(ForwardAE), 32'd2);
    RdM = 0;
    runCycle("t1_fwdWb");
    checkVal("t1_fwdA_wb", 32'(ForwardAE), 32'd1);

    // 2: x0 never forwarded
    clearIn(); Rs2E = 0; RdM = 0; RegWriteM = 1;
    runCycle("t2_x0");
    checkVal("t2_fwdB_x0", 32'(ForwardBE), 32'd0);

    // 3: load-use stall for one cycle
    clearIn(); ResultSrcE = 2'b01; RdE = 7; Rs2D = 7;
    runCycle("t3_loadUse");
    checkVal("t3_lw_ctl", 32'({StallF, StallD, FlushE, FlushD}), 32'b1110);
    clearIn();
    runCycle("t3_release");

    // 4: taken branch
    clearIn(); PCSrcE = 1;
    runCycle("t4_branch");
    checkVal("t4_br_ctl", 32'({FlushD, FlushE, StallF, StallD}), 32'b1100);
    clearIn();
    runCycle("t4_after");

    // 5: access ready after 3 cycles stalls exactly 3 cycles
    clearIn(); MemReqM = 1; n = 0;
    for (int i = 0; i < 4; i++) begin
      MemReadyM = (i == 3);
      runCycle("t5_mem");
      n += int'(lastStall);
    end
    checkVal("t5_stallLen", 32'(n), 32'd3);
    clearIn();
    runCycle("t5_idle");
    checkVal("t5_noStall", 32'(lastStall), 32'd0);
    MemReqM = 1; MemReadyM = 1;
    runCycle("t5_readyNow");
    checkVal("t5_sameCycleReady", 32'(lastStall), 32'd0);

    // Boundary: ready on the last allowed not-ready cycle's successor
    clearIn(); MemReqM = 1;
    for (int i = 0; i < MEM_TIMEOUT; i++) begin
      MemReadyM = (i == MEM_TIMEOUT - 1);
      runCycle("t5b_almost");
    end
    checkVal("t5b_noErr", 32'(MemErr), 32'd0);

    // Reset in the middle of a wait
    clearIn(); MemReqM = 1;
    for (int i = 0; i < 3; i++) runCycle("tr_wait");
    doReset();
    runCycle("tr_idle");

    // 6: timeout -> ERROR, sticky stalls, cleared by reset
    clearIn(); MemReqM = 1;
    for (int i = 0; i < MEM_TIMEOUT; i++) runCycle("t6_wait");
    checkVal("t6_memErr", 32'(MemErr), 32'd1);
    clearIn(); MemReadyM = 1; PCSrcE = 1;
    runCycle("t6_stick");
    checkVal("t6_stickStall", 32'(lastStall), 32'd1);
    doReset();
    runCycle("t6_cleared");
    checkVal("t6_clearedStall", 32'(lastStall), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(99) < 2) begin
        doReset();
      end else begin
        Rs1D = 5'($urandom_range(3)); Rs2D = 5'($urandom_range(3));
        Rs1E = 5'($urandom_range(3)); Rs2E = 5'($urandom_range(3));
        RdE  = 5'($urandom_range(3)); RdM  = 5'($urandom_range(3));
        RdW  = 5'($urandom_range(3));
        ResultSrcE = 2'($urandom_range(3));
        RegWriteM = 1'($urandom_range(1)); RegWriteW = 1'($urandom_range(1));
        PCSrcE    = ($urandom_range(3) == 0);
        MemReqM   = ($urandom_range(2) == 0);
        MemReadyM = ($urandom_range(3) != 0);
        runCycle("rand");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCnt, errCnt);
    $finish;
  end

endmodule
